// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, access widths
// and the memory command bundle that gets muxed onto the shared port.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_WORD = 2'b10
  } width_t;

  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic        extend;
    logic [1:0]  width;
  } mem_cmd_t;

  // Fetches are always plain word reads.
  function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
    mem_cmd_t c;
    c.addr   = addr;
    c.write  = 1'b0;
    c.wdata  = '0;
    c.extend = 1'b0;
    c.width  = WIDTH_WORD;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port of the arbiter.
// Handshake: a requester raises x_req with stable fields and keeps them until the
// cycle x_ack is high; the ack cycle completes the transfer, x_rdata is valid the
// cycle after. The memory side completes a transfer in any cycle m_req && m_ack.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write;
  logic [31:0] d_wdata;
  logic        d_extend;
  logic [1:0]  d_width;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        m_req;
  logic [31:0] m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic        m_extend;
  logic [1:0]  m_width;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_addr, d_write, d_wdata, d_extend, d_width,
    output d_ack, d_rdata,
    output m_req, m_addr, m_write, m_wdata, m_extend, m_width,
    input  m_ack, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_addr, d_write, d_wdata, d_extend, d_width,
    input  d_ack, d_rdata,
    input  m_req, m_addr, m_write, m_wdata, m_extend, m_width,
    output m_ack, m_rdata
  );

endinterface

// File: rtl/starve_counter.sv
// Counts consecutive data grants taken while a fetch is waiting; saturates at
// LIMIT so the arbiter can force the next grant to the fetch port.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req,
  input  logic i_ack,
  input  logic d_ack,
  output logic at_limit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (!i_req || i_ack) begin
      count_q <= '0;
    end else if (d_ack && (count_q != CW'(LIMIT))) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign at_limit = (count_q == CW'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: data has priority over fetch, with a starvation
// guard; the winner is put on the shared port in the same cycle it is chosen.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus,
  output arb_state_t     dbg_state
);

  arb_state_t  state_q, state_d;
  logic        at_limit;
  logic        grant_i, grant_d;
  logic        sel_i, sel_d;
  logic        m_req_c, i_ack_c, d_ack_c;
  logic [31:0] i_rdata_q, d_rdata_q;
  mem_cmd_t    i_cmd, d_cmd, m_cmd;

  // Winner selection, only meaningful while IDLE.
  always_comb begin
    grant_i = bus.i_req && (!bus.d_req || at_limit);
    grant_d = bus.d_req && !grant_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // An owner dropping its request is a protocol violation; fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_i && !bus.m_ack)      state_d = BUSY_I;
        else if (grant_d && !bus.m_ack) state_d = BUSY_D;
      end
      BUSY_I: if (bus.m_ack || !bus.i_req) state_d = IDLE;
      BUSY_D: if (bus.m_ack || !bus.d_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (state_q)
      IDLE: begin
        sel_i = grant_i;
        sel_d = grant_d;
      end
      BUSY_I: sel_i = 1'b1;
      BUSY_D: sel_d = 1'b1;
      default: begin
        sel_i = 1'b0;
        sel_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    i_cmd        = fetch_cmd(bus.i_addr);
    d_cmd.addr   = bus.d_addr;
    d_cmd.write  = bus.d_write;
    d_cmd.wdata  = bus.d_wdata;
    d_cmd.extend = bus.d_extend;
    d_cmd.width  = bus.d_width;
    m_cmd        = sel_i ? i_cmd : d_cmd;
  end

  // Reset gating keeps the shared port and acks quiet while reset_n is low.
  assign m_req_c = reset_n && ((sel_i && bus.i_req) || (sel_d && bus.d_req));
  assign i_ack_c = m_req_c && bus.m_ack && sel_i;
  assign d_ack_c = m_req_c && bus.m_ack && sel_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_ack_c) i_rdata_q <= bus.m_rdata;
      if (d_ack_c) d_rdata_q <= bus.m_rdata;
    end
  end

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (bus.i_req),
    .i_ack    (i_ack_c),
    .d_ack    (d_ack_c),
    .at_limit (at_limit)
  );

  assign bus.m_req    = m_req_c;
  assign bus.m_addr   = m_cmd.addr;
  assign bus.m_write  = m_cmd.write;
  assign bus.m_wdata  = m_cmd.wdata;
  assign bus.m_extend = m_cmd.extend;
  assign bus.m_width  = m_cmd.width;
  assign bus.i_ack    = i_ack_c;
  assign bus.d_ack    = d_ack_c;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign dbg_state    = state_q;

  a_fetch_owner_holds_req: assert property (
    @(posedge clk) disable iff (!reset_n) (state_q == BUSY_I) |-> bus.i_req);
  a_data_owner_holds_req: assert property (
    @(posedge clk) disable iff (!reset_n) (state_q == BUSY_D) |-> bus.d_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inline checks.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        reset_n;
  arb_state_t  dbg_state;
  logic        mem_auto;
  logic        man_ack;
  logic [31:0] man_rdata;
  int          tests_run;
  int          tests_failed;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Memory model: auto mode acks in the issue cycle with data = addr ^ DEAD0000.
  assign bus.m_ack   = mem_auto ? bus.m_req : man_ack;
  assign bus.m_rdata = mem_auto ? (bus.m_addr ^ 32'hDEAD_0000) : man_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.d_extend = 1'b0; bus.d_width = 2'b10;
    man_ack = 1'b0; man_rdata = '0; mem_auto = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    tick(); tick();
    tests_run++; if (bus.m_req !== 1'b0) begin tests_failed++; $display("FAIL reset_m_req: got %b want 0", bus.m_req); end
    tests_run++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_acks: got %b%b want 00", bus.i_ack, bus.d_ack); end
    tests_run++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h %h want 0 0", bus.i_rdata, bus.d_rdata); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    bus.i_req = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bus.i_req = 1'b1; bus.i_addr = 32'h100; man_ack = 1'b0;
    #1;
    tests_run++; if (bus.m_req !== 1'b1) begin tests_failed++; $display("FAIL fetch_m_req: got %b want 1", bus.m_req); end
    tests_run++; if (bus.m_addr !== 32'h100) begin tests_failed++; $display("FAIL fetch_m_addr: got %h want 100", bus.m_addr); end
    tests_run++; if (bus.m_width !== 2'b10 || bus.m_write !== 1'b0 || bus.m_extend !== 1'b0) begin tests_failed++; $display("FAIL fetch_fields: got w%b wr%b ex%b want w10 wr0 ex0", bus.m_width, bus.m_write, bus.m_extend); end
    tick();
    tests_run++; if (dbg_state !== BUSY_I) begin tests_failed++; $display("FAIL fetch_busy: got %0d want %0d", dbg_state, BUSY_I); end
    tick();
    man_ack = 1'b1; man_rdata = 32'hCAFE_0100;
    #1;
    tests_run++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin tests_failed++; $display("FAIL fetch_ack: got i%b d%b want i1 d0", bus.i_ack, bus.d_ack); end
    tick();
    tests_run++; if (bus.i_rdata !== 32'hCAFE_0100) begin tests_failed++; $display("FAIL fetch_rdata: got %h want cafe0100", bus.i_rdata); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL fetch_idle: got %0d want %0d", dbg_state, IDLE); end
    bus.i_req = 1'b0; man_ack = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_addr = 32'h2000; bus.d_write = 1'b0; bus.d_width = 2'b10;
    man_ack = 1'b0;
    #1;
    tests_run++; if (bus.m_addr !== 32'h2000) begin tests_failed++; $display("FAIL prio_data_first: got %h want 2000", bus.m_addr); end
    tick();
    man_ack = 1'b1; man_rdata = 32'h1111_2222;
    #1;
    tests_run++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin tests_failed++; $display("FAIL prio_d_ack: got d%b i%b want d1 i0", bus.d_ack, bus.i_ack); end
    tick();
    tests_run++; if (bus.d_rdata !== 32'h1111_2222) begin tests_failed++; $display("FAIL prio_d_rdata: got %h want 11112222", bus.d_rdata); end
    bus.d_req = 1'b0; man_ack = 1'b1; man_rdata = 32'h3333_4444;
    #1;
    tests_run++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h100) begin tests_failed++; $display("FAIL prio_fetch_next: got req%b %h want req1 100", bus.m_req, bus.m_addr); end
    tests_run++; if (bus.i_ack !== 1'b1) begin tests_failed++; $display("FAIL prio_i_ack: got %b want 1", bus.i_ack); end
    tick();
    bus.i_req = 1'b0; man_ack = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    bus.i_req = 1'b1; bus.i_addr = 32'h200; man_ack = 1'b0;
    tick();
    bus.d_req = 1'b1; bus.d_addr = 32'h3000;
    #1;
    tests_run++; if (bus.m_addr !== 32'h200 || bus.d_ack !== 1'b0) begin tests_failed++; $display("FAIL hold_owner: got %h d_ack%b want 200 d_ack0", bus.m_addr, bus.d_ack); end
    tick();
    tests_run++; if (dbg_state !== BUSY_I || bus.m_addr !== 32'h200) begin tests_failed++; $display("FAIL hold_busy: got st%0d %h want st%0d 200", dbg_state, bus.m_addr, BUSY_I); end
    man_ack = 1'b1; man_rdata = 32'h0000_0200;
    #1;
    tests_run++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin tests_failed++; $display("FAIL hold_i_ack: got i%b d%b want i1 d0", bus.i_ack, bus.d_ack); end
    tick();
    bus.i_req = 1'b0;
    #1;
    tests_run++; if (bus.m_addr !== 32'h3000 || bus.d_ack !== 1'b1) begin tests_failed++; $display("FAIL hold_data_served: got %h d_ack%b want 3000 d_ack1", bus.m_addr, bus.d_ack); end
    tick();
    bus.d_req = 1'b0; man_ack = 1'b0;
    tick();
  endtask

  task automatic test_starve();
    logic exp_i;
    mem_auto = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_addr = 32'h5000; bus.d_write = 1'b0;
    for (int c = 0; c < 10; c++) begin
      exp_i = ((c % 5) == 4);
      #1;
      tests_run++; if (bus.i_ack !== exp_i || bus.d_ack !== !exp_i) begin tests_failed++; $display("FAIL starve_cycle%0d: got i%b d%b want i%b d%b", c, bus.i_ack, bus.d_ack, exp_i, !exp_i); end
      tick();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; mem_auto = 1'b0;
    tick();
  endtask

  task automatic test_write();
    bus.d_req = 1'b1; bus.d_addr = 32'h6001; bus.d_write = 1'b1; bus.d_width = 2'b00;
    bus.d_wdata = 32'hA5; bus.d_extend = 1'b1;
    man_ack = 1'b1; man_rdata = 32'h0000_00FF;
    #1;
    tests_run++; if (bus.m_write !== 1'b1 || bus.m_width !== 2'b00 || bus.m_wdata !== 32'hA5) begin tests_failed++; $display("FAIL write_fields: got wr%b w%b %h want wr1 w00 a5", bus.m_write, bus.m_width, bus.m_wdata); end
    tests_run++; if (bus.m_extend !== 1'b1 || bus.m_addr !== 32'h6001) begin tests_failed++; $display("FAIL write_ext_addr: got ex%b %h want ex1 6001", bus.m_extend, bus.m_addr); end
    tests_run++; if (bus.d_ack !== 1'b1) begin tests_failed++; $display("FAIL write_ack: got %b want 1", bus.d_ack); end
    tick();
    bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_extend = 1'b0; bus.d_width = 2'b10; man_ack = 1'b0;
    tests_run++; if (bus.d_rdata !== 32'h0000_00FF) begin tests_failed++; $display("FAIL write_rdata: got %h want 000000ff", bus.d_rdata); end
    tests_run++; if (bus.i_rdata !== 32'hDEAD_0400) begin tests_failed++; $display("FAIL write_i_rdata_held: got %h want dead0400", bus.i_rdata); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL write_same_cycle_idle: got %0d want %0d", dbg_state, IDLE); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    mem_auto = 1'b1;
    bus.d_req = 1'b1; bus.d_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 32'h8000 + 32'(k * 4);
      bus.d_addr = a;
      #1;
      tests_run++; if (bus.d_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_ack%0d: got %b want 1", k, bus.d_ack); end
      tick();
      tests_run++; if (bus.d_rdata !== (a ^ 32'hDEAD_0000)) begin tests_failed++; $display("FAIL b2b_rdata%0d: got %h want %h", k, bus.d_rdata, a ^ 32'hDEAD_0000); end
    end
    bus.d_req = 1'b0; mem_auto = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.d_req = 1'b1; bus.d_addr = 32'h7000; bus.d_write = 1'b0; man_ack = 1'b0;
    tick();
    tests_run++; if (dbg_state !== BUSY_D) begin tests_failed++; $display("FAIL rst_mid_busy: got %0d want %0d", dbg_state, BUSY_D); end
    reset_n = 1'b0; man_ack = 1'b1; man_rdata = 32'h7777_7777;
    #1;
    tests_run++; if (bus.m_req !== 1'b0 || bus.d_ack !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_quiet: got req%b d_ack%b want 0 0", bus.m_req, bus.d_ack); end
    tick();
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, IDLE); end
    tests_run++; if (bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_rdata: got %h %h want 0 0", bus.d_rdata, bus.i_rdata); end
    reset_n = 1'b1; bus.d_req = 1'b0;
    #1;
    tests_run++; if (bus.d_ack !== 1'b0 || bus.m_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_ack: got d_ack%b req%b want 0 0", bus.d_ack, bus.m_req); end
    tick();
    man_ack = 1'b0;
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_hold();
    test_starve();
    test_write();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
